// File: rtl/panda_pkg.sv
// panda_pkg
//   Shared types for the panda core's decode and execute stages.
//   - alu_operator_e : operation selector on the ALU request interface.
//   - OPCODE_*       : RV32I major opcodes that produce ALU requests.
//   - alu_decode_t   : one decoded ALU request (operator, operands, rd,
//                      write-back enable, branch flag, illegal flag).
//   - imm_i / imm_u  : sign-extended RV32I immediate extraction helpers.
package panda_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB,
        ALU_SLL,
        ALU_LT,
        ALU_LTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_EQ,
        ALU_NE,
        ALU_GE,
        ALU_GEU
    } alu_operator_e;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_operator_e   operator;
        logic [XLEN-1:0] operand_a;
        logic [XLEN-1:0] operand_b;
        logic [4:0]      rd;
        logic            rd_we;
        logic            branch;
        logic            illegal;
    } alu_decode_t;

    // Idle / reset content of an ALU request: ADD of zeros, no side effects.
    localparam alu_decode_t ALU_DECODE_RESET = '{
        operator:  ALU_ADD,
        operand_a: '0,
        operand_b: '0,
        rd:        '0,
        rd_we:     1'b0,
        branch:    1'b0,
        illegal:   1'b0
    };

    // I-type immediate, instr[31:20], sign-extended.
    function automatic logic [XLEN-1:0] imm_i(input logic [31:0] instr);
        return {{(XLEN-12){instr[31]}}, instr[31:20]};
    endfunction

    // U-type immediate, instr[31:12] in the upper bits, low 12 bits zero.
    function automatic logic [XLEN-1:0] imm_u(input logic [31:0] instr);
        return {instr[31:12], 12'b0};
    endfunction

endpackage

// File: rtl/panda_alu_decode_comb.sv
// panda_alu_decode_comb
//   Purely combinational RV32I decoder producing one ALU request.
//   Ports:
//     instr_i     in  32    instruction word
//     pc_i        in  XLEN  PC of the instruction (AUIPC operand)
//     rs1_data_i  in  XLEN  first register operand
//     rs2_data_i  in  XLEN  second register operand
//     decode_o    out alu_decode_t  decoded operator, operands and flags
//   Anything that does not decode becomes ADD 0,0 with illegal set,
//   no write-back and no branch; rd still reflects instr[11:7].
module panda_alu_decode_comb
    import panda_pkg::*;
(
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output alu_decode_t     decode_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    // For OP-IMM shifts this field is imm[11:5], checked the same way.
    assign funct7 = instr_i[31:25];

    alu_decode_t dec;
    logic        legal;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no
        // path through the case statements can leave one unassigned and
        // infer a latch.
        dec    = ALU_DECODE_RESET;
        dec.rd = instr_i[11:7];
        legal  = 1'b0;

        case (opcode)
            OPCODE_OP: begin
                dec.operand_a = rs1_data_i;
                dec.operand_b = rs2_data_i;
                dec.rd_we     = 1'b1;
                legal         = 1'b1;
                if (funct7 == FUNCT7_BASE) begin
                    case (funct3)
                        3'b000:  dec.operator = ALU_ADD;
                        3'b001:  dec.operator = ALU_SLL;
                        3'b010:  dec.operator = ALU_LT;
                        3'b011:  dec.operator = ALU_LTU;
                        3'b100:  dec.operator = ALU_XOR;
                        3'b101:  dec.operator = ALU_SRL;
                        3'b110:  dec.operator = ALU_OR;
                        default: dec.operator = ALU_AND;
                    endcase
                end else if (funct7 == FUNCT7_ALT && funct3 == 3'b000) begin
                    dec.operator = ALU_SUB;
                end else if (funct7 == FUNCT7_ALT && funct3 == 3'b101) begin
                    dec.operator = ALU_SRA;
                end else begin
                    legal = 1'b0;
                end
            end

            OPCODE_OP_IMM: begin
                dec.operand_a = rs1_data_i;
                dec.operand_b = imm_i(instr_i);
                dec.rd_we     = 1'b1;
                legal         = 1'b1;
                case (funct3)
                    3'b000: dec.operator = ALU_ADD;
                    3'b001: begin
                        // SLLI: only the all-zero upper immediate is defined.
                        dec.operator = ALU_SLL;
                        legal        = (funct7 == FUNCT7_BASE);
                    end
                    3'b010: dec.operator = ALU_LT;
                    3'b011: dec.operator = ALU_LTU;
                    3'b100: dec.operator = ALU_XOR;
                    3'b101: begin
                        // SRLI / SRAI are told apart by imm[11:5].
                        if (funct7 == FUNCT7_BASE) begin
                            dec.operator = ALU_SRL;
                        end else if (funct7 == FUNCT7_ALT) begin
                            dec.operator = ALU_SRA;
                        end else begin
                            legal = 1'b0;
                        end
                    end
                    3'b110:  dec.operator = ALU_OR;
                    default: dec.operator = ALU_AND;
                endcase
            end

            OPCODE_LUI: begin
                dec.operator  = ALU_ADD;
                dec.operand_a = '0;
                dec.operand_b = imm_u(instr_i);
                dec.rd_we     = 1'b1;
                legal         = 1'b1;
            end

            OPCODE_AUIPC: begin
                dec.operator  = ALU_ADD;
                dec.operand_a = pc_i;
                dec.operand_b = imm_u(instr_i);
                dec.rd_we     = 1'b1;
                legal         = 1'b1;
            end

            OPCODE_BRANCH: begin
                dec.operand_a = rs1_data_i;
                dec.operand_b = rs2_data_i;
                dec.branch    = 1'b1;
                legal         = 1'b1;
                case (funct3)
                    3'b000:  dec.operator = ALU_EQ;
                    3'b001:  dec.operator = ALU_NE;
                    3'b100:  dec.operator = ALU_LT;
                    3'b101:  dec.operator = ALU_GE;
                    3'b110:  dec.operator = ALU_LTU;
                    3'b111:  dec.operator = ALU_GEU;
                    default: legal = 1'b0;
                endcase
            end

            default: legal = 1'b0;
        endcase

        // Illegal beats collapse to a side-effect-free request so a later
        // stage can trap on illegal without anything being committed.
        if (!legal) begin
            dec         = ALU_DECODE_RESET;
            dec.rd      = instr_i[11:7];
            dec.illegal = 1'b1;
        end
    end

    assign decode_o = dec;

endmodule

// File: rtl/panda_alu_decoder.sv
// panda_alu_decoder
//   Registered decode stage producing the ALU request for execute.
//   A single valid/ready output register holds one decoded beat.
//   Ports:
//     clk_i, rst_i             clock, synchronous active-high reset
//     flush_i                  drop the held beat and any beat accepted now
//     in_valid_i / in_ready_o  upstream handshake
//     instr_i, pc_i            instruction and its PC
//     rs1_data_i, rs2_data_i   register operands
//     out_valid_o / out_ready_i downstream handshake
//     operator_o               ALU operator
//     operand_a_o, operand_b_o ALU operands
//     rd_o, rd_we_o            destination register and write-back enable
//     branch_o                 result is a branch condition
//     illegal_o                instruction did not decode
module panda_alu_decoder
    import panda_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,

    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [Width-1:0] pc_i,
    input  logic [Width-1:0] rs1_data_i,
    input  logic [Width-1:0] rs2_data_i,

    output logic             out_valid_o,
    input  logic             out_ready_i,
    output alu_operator_e    operator_o,
    output logic [Width-1:0] operand_a_o,
    output logic [Width-1:0] operand_b_o,
    output logic [4:0]       rd_o,
    output logic             rd_we_o,
    output logic             branch_o,
    output logic             illegal_o
);

    alu_decode_t dec;
    alu_decode_t out_q;
    logic        out_valid_q;
    logic        accept;

    panda_alu_decode_comb u_decode (
        .instr_i    (instr_i),
        .pc_i       (pc_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .decode_o   (dec)
    );

    // The register can take a new beat when empty or when its current beat
    // leaves this cycle; flush deliberately does not gate readiness.
    assign in_ready_o = ~out_valid_q | out_ready_i;
    assign accept     = in_valid_i & in_ready_o;

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_i) begin
            out_valid_q <= 1'b0;
            // NOTE: the data register is reset as well, not just valid,
            // because its idle content is visible on the ports.
            out_q       <= ALU_DECODE_RESET;
        end else begin
            if (flush_i) begin
                out_valid_q <= 1'b0;
            end else if (accept) begin
                out_valid_q <= 1'b1;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end

            // On a flushed accept the data still loads; valid=0 hides it.
            if (accept) begin
                out_q <= dec;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign operator_o  = out_q.operator;
    assign operand_a_o = out_q.operand_a;
    assign operand_b_o = out_q.operand_b;
    assign rd_o        = out_q.rd;
    assign rd_we_o     = out_q.rd_we;
    assign branch_o    = out_q.branch;
    assign illegal_o   = out_q.illegal;

endmodule

// File: doc/panda_alu_decoder.md
# panda_alu_decoder

Registered decode stage that produces the ALU's request: it turns an RV32I instruction plus its register/PC operands into `panda_pkg::alu_operator_e` and the two ALU operands. Output is held in a single valid/ready pipeline register feeding the execute stage's ALU. It sits between issue and execute, and is the producer side of the ALU's operator/operand interface.

## Interface
- `Width`, 32: datapath width. Only 32 (RV32I) is supported.

- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `flush_i` in 1: discard the registered beat and any beat accepted in the same cycle.
- `in_valid_i` in 1: an instruction is offered.
- `in_ready_o` out 1: the stage can accept it.
- `instr_i` in 32: instruction word.
- `pc_i` in Width: PC of the instruction.
- `rs1_data_i`, `rs2_data_i` in Width: register operands.
- `out_valid_o` out 1: the output register holds a beat.
- `out_ready_i` in 1: execute consumes the beat.
- `operator_o` out `alu_operator_e`: ALU operator.
- `operand_a_o`, `operand_b_o` out Width: ALU operands.
- `rd_o` out 5: destination register (`instr[11:7]`).
- `rd_we_o` out 1: result is written back.
- `branch_o` out 1: the ALU result is a branch condition.
- `illegal_o` out 1: the instruction is not decodable.

## Operation
Decode rules (I-imm, B-imm and U-imm follow the RV32I encodings; immediates are sign-extended to Width):
- **OP (0110011), funct7 0000000:** funct3 000..111 maps to ADD, SLL, LT, LTU, XOR, SRL, OR, AND.
- **OP, funct7 0100000:** funct3 000 gives SUB; 101 gives SRA. Any other funct7/funct3 is illegal. a=rs1, b=rs2, rd_we=1.
- **OP-IMM (0010011):** same funct3 map, no SUB. a=rs1, b=I-imm.
  - SLLI/SRLI require `imm[11:5]`=0000000.
  - SRAI requires 0100000.
  - Any other shift encoding is illegal. rd_we=1.
- **LUI (0110111):** ADD, a=0, b=U-imm, rd_we=1.
- **AUIPC (0010111):** ADD, a=pc_i, b=U-imm, rd_we=1.
- **BRANCH (1100011):** funct3 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010 and 011 are illegal. a=rs1, b=rs2, branch_o=1, rd_we=0.
- **Any other opcode, or an illegal case above:** illegal_o=1, operator ADD, operands 0, rd_we=0, branch_o=0.
- **Handshake:**
  - `in_ready_o = ~out_valid_o | out_ready_i` (combinational path from `out_ready_i`).
  - Accept when `in_valid_i & in_ready_o`; all output fields load together.
  - When not accepting, all output fields hold. While `out_valid_o & ~out_ready_i`, outputs stay stable.
- **out_valid next state:**
  - `rst_i`: 0.
  - else `flush_i`: 0.
  - else accept: 1.
  - else `out_ready_i`: 0.
  - else: hold.
- **Flush:**
  - Has priority over a simultaneous accept. The accepted beat is dropped; data regs may load but valid=0.
  - `in_ready_o` is not gated by `flush_i`.
- **Illegal beats:** still handed downstream with `illegal_o`=1. The trap decision belongs to a later stage.

## Timing
- Latency: 1 cycle from accept to `out_valid_o`. Throughput: 1 beat/cycle with `out_ready_i` held high.
- Reset values (next edge with `rst_i`=1):
  - out_valid 0.
  - operator ALU_ADD.
  - operands, rd 0.
  - rd_we, branch, illegal 0.
  - `rst_i` mid-stall drops the held beat.
- Accept and consume in the same cycle: the old beat leaves and the new one loads, with no bubble.
- Flush and consume in the same cycle: the handshake completes downstream; the register empties.

## Structure
- `panda_pkg` gains opcode constants (`OPCODE_OP`, `OPCODE_OP_IMM`, `OPCODE_LUI`, `OPCODE_AUIPC`, `OPCODE_BRANCH`) and `alu_decode_t`, a struct holding operator, operands, rd, rd_we, branch and illegal. `alu_operator_e` is reused unchanged.
- Sub-module `panda_alu_decode_comb` is purely combinational: instr, pc and rs data in, `alu_decode_t` out.
- The top level holds only the valid/ready register and the flush/reset logic.

## Test plan
- **Reset:** `rst_i`=1 for 2 cycles with `in_valid_i`=1 → out_valid 0, operator ALU_ADD, operands 0, `in_ready_o`=1.
- **R-type SUB:** instr 0x40208033, rs1=5, rs2=7, out_ready=1 → next cycle ALU_SUB, a=5, b=7, rd=0, rd_we=1.
- **Immediates:** instr 0xFFF00093 (ADDI -1) → ALU_ADD, b=0xFFFFFFFF. AUIPC 0x12345017 with pc 0x100 → a=0x100, b=0x12345000.
- **Branch and illegal:** BGEU 0x0020F063 → ALU_GEU, branch_o=1, rd_we=0. funct3=010 branch, or SLLI with `imm[11:5]`=0100000 → illegal_o=1, ALU_ADD.
- **Backpressure:** out_ready=0 for 3 cycles with a new beat offered → `in_ready_o`=0, outputs stable. When out_ready=1, the new beat loads with no bubble.
- **Flush:** flush_i together with accept → out_valid 0 next cycle. Random decode vs. reference model: no loss or duplication of beats.
